// File: rtl/pll_lock_sequencer.sv
// PLL lock handshake sequencer: synchronizes LOCKED, qualifies it, pulses the PLL reset on timeout.
// Optional lock-loss / timeout event counters are built when LOCK_SEQ_STATUS_EN is defined.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             locked_i,
  output logic             pll_rst_o,
  output logic             rst_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(32'd1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   pll_rst_r;
  logic                   rst_r;
  logic                   ready_r;
  logic                   pll_rst_d_s;
  logic                   rst_d_s;
  logic                   ready_d_s;

  // LOCKED synchronizer chain; only its last stage is used for decisions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], locked_i};
    end
  end

  assign lock_s = sync_r[SYNC_STAGES-1];

  // State, shared cycle counter and output flops (outputs follow the next-state decode)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_PLL_RESET;
      cnt_r     <= {CW{1'b0}};
      pll_rst_r <= 1'b1;
      rst_r     <= 1'b1;
      ready_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pll_rst_r <= pll_rst_d_s;
      rst_r     <= rst_d_s;
      ready_r   <= ready_d_s;
    end
  end

  // Next-state decode; a loss in RUN only re-enters WAIT_LOCK so the PLL may relock unaided
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_PLL_RESET: begin
        if (cnt_r == PLL_RST_LAST) state_nxt_s = ST_WAIT_LOCK;
        else                       state_nxt_s = ST_PLL_RESET;
      end
      ST_WAIT_LOCK: begin
        if (lock_s)                     state_nxt_s = ST_STABLE;
        else if (cnt_r == TIMEOUT_LAST) state_nxt_s = ST_PLL_RESET;
        else                            state_nxt_s = ST_WAIT_LOCK;
      end
      ST_STABLE: begin
        if (!lock_s)                   state_nxt_s = ST_WAIT_LOCK;
        else if (cnt_r == STABLE_LAST) state_nxt_s = ST_RUN;
        else                           state_nxt_s = ST_STABLE;
      end
      ST_RUN: begin
        if (!lock_s) state_nxt_s = ST_WAIT_LOCK;
        else         state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_PLL_RESET;
    endcase
  end

  // Output and counter decode from the next state
  always_comb begin
    pll_rst_d_s = (state_nxt_s == ST_PLL_RESET);
    rst_d_s     = (state_nxt_s != ST_RUN);
    ready_d_s   = (state_nxt_s == ST_RUN);
    if (state_nxt_s != state_r) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  assign pll_rst_o = pll_rst_r;
  assign rst_o     = rst_r;
  assign ready_o   = ready_r;

`ifdef LOCK_SEQ_STATUS_EN
  localparam logic [CNT_W-1:0] EVT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EVT_ONE = CNT_W'(32'd1);

  logic             loss_evt_s;
  logic             timeout_evt_s;
  logic [CNT_W-1:0] loss_cnt_r;
  logic [CNT_W-1:0] timeout_cnt_r;

  assign loss_evt_s    = (state_r == ST_RUN) && !lock_s;
  assign timeout_evt_s = (state_r == ST_WAIT_LOCK) && !lock_s && (cnt_r == TIMEOUT_LAST);

  // Saturating event counters, cleared only by rst_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loss_cnt_r    <= {CNT_W{1'b0}};
      timeout_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (loss_evt_s && (loss_cnt_r != EVT_MAX)) begin
        loss_cnt_r <= loss_cnt_r + EVT_ONE;
      end else begin
        loss_cnt_r <= loss_cnt_r;
      end
      if (timeout_evt_s && (timeout_cnt_r != EVT_MAX)) begin
        timeout_cnt_r <= timeout_cnt_r + EVT_ONE;
      end else begin
        timeout_cnt_r <= timeout_cnt_r;
      end
    end
  end

  assign loss_cnt_o    = loss_cnt_r;
  assign timeout_cnt_o = timeout_cnt_r;
`else
  assign loss_cnt_o    = {CNT_W{1'b0}};
  assign timeout_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer (small parameter set, edge-numbered vectors).
module tb_pll_lock_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       locked_i = 1'b0;
  logic       pll_rst_o;
  logic       rst_o;
  logic       ready_o;
  logic [1:0] loss_cnt_o;
  logic [1:0] timeout_cnt_o;

  int n_vec = 0;
  int n_err = 0;

`ifdef LOCK_SEQ_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  pll_lock_sequencer #(
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (4),
    .STABLE_CYCLES  (8),
    .TIMEOUT_CYCLES (32),
    .CNT_W          (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .locked_i      (locked_i),
    .pll_rst_o     (pll_rst_o),
    .rst_o         (rst_o),
    .ready_o       (ready_o),
    .loss_cnt_o    (loss_cnt_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // After this, the next tick() lands just after edge 1
  task automatic do_reset(input logic lock);
    rst_i    = 1'b1;
    locked_i = lock;
    repeat (3) tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    n_vec++;
    if ({pll_rst_o, rst_o, ready_o} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_outputs: got pll_rst/rst/ready=%b expected 110", {pll_rst_o, rst_o, ready_o});
    end
    n_vec++;
    if ({loss_cnt_o, timeout_cnt_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_counters: got %b expected 0000", {loss_cnt_o, timeout_cnt_o});
    end
  endtask

  task automatic test_power_up();
    logic exp_pll, exp_rst;
    do_reset(1'b1);
    for (int e = 1; e <= 14; e++) begin
      tick();
      exp_pll = (e <= 3);
      exp_rst = (e < 13);
      n_vec++;
      if ({pll_rst_o, rst_o, ready_o} !== {exp_pll, exp_rst, ~exp_rst}) begin
        n_err++;
        $display("FAIL power_up edge %0d: got pll_rst/rst/ready=%b expected %b", e,
                 {pll_rst_o, rst_o, ready_o}, {exp_pll, exp_rst, ~exp_rst});
      end
    end
  endtask

  task automatic test_timeout();
    logic exp_pll;
    logic [1:0] exp_to;
    do_reset(1'b0);
    for (int e = 1; e <= 76; e++) begin
      tick();
      exp_pll = (e <= 3) || (e >= 36 && e <= 39) || (e >= 72 && e <= 75);
      n_vec++;
      if (pll_rst_o !== exp_pll || rst_o !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_seq edge %0d: got pll_rst/rst=%b%b expected %b1", e, pll_rst_o, rst_o, exp_pll);
      end
      if (e == 35 || e == 36 || e == 71 || e == 72) begin
        exp_to = (e == 35) ? 2'd0 : ((e == 72) ? 2'd2 : 2'd1);
        if (!STATUS_EN) exp_to = 2'd0;
        n_vec++;
        if (timeout_cnt_o !== exp_to) begin
          n_err++;
          $display("FAIL timeout_cnt edge %0d: got %0d expected %0d", e, timeout_cnt_o, exp_to);
        end
      end
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_vec++;
    if (timeout_cnt_o !== 2'd0 || pll_rst_o !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_clear: got cnt=%0d pll_rst=%b expected 0 1", timeout_cnt_o, pll_rst_o);
    end
  endtask

  task automatic test_loss();
    logic exp_rst;
    logic [1:0] exp_loss;
    do_reset(1'b1);
    repeat (13) tick();
    locked_i = 1'b0;
    for (int e = 14; e <= 28; e++) begin
      tick();
      if (e == 16) locked_i = 1'b1;
      exp_rst  = (e >= 16 && e <= 26);
      exp_loss = (STATUS_EN && e >= 16) ? 2'd1 : 2'd0;
      n_vec++;
      if (rst_o !== exp_rst || pll_rst_o !== 1'b0 || ready_o !== ~exp_rst || loss_cnt_o !== exp_loss) begin
        n_err++;
        $display("FAIL loss_run edge %0d: got rst/pll_rst/ready/loss=%b%b%b/%0d expected %b0%b/%0d", e,
                 rst_o, pll_rst_o, ready_o, loss_cnt_o, exp_rst, ~exp_rst, exp_loss);
      end
    end
  endtask

  task automatic test_stable_abort();
    logic exp_rst;
    do_reset(1'b1);
    for (int e = 1; e <= 23; e++) begin
      tick();
      if (e == 8)  locked_i = 1'b0;
      if (e == 11) locked_i = 1'b1;
      exp_rst = (e < 22);
      n_vec++;
      if (rst_o !== exp_rst || pll_rst_o !== (e <= 3) || loss_cnt_o !== 2'd0) begin
        n_err++;
        $display("FAIL stable_abort edge %0d: got rst/pll_rst/loss=%b%b/%0d expected %b%b/0", e,
                 rst_o, pll_rst_o, loss_cnt_o, exp_rst, (e <= 3));
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_loss;
    do_reset(1'b1);
    repeat (13) tick();
    for (int i = 1; i <= 5; i++) begin
      locked_i = 1'b0;
      repeat (3) tick();
      locked_i = 1'b1;
      repeat (11) tick();
      exp_loss = STATUS_EN ? ((i > 3) ? 2'd3 : 2'(i)) : 2'd0;
      n_vec++;
      if (rst_o !== 1'b0 || loss_cnt_o !== exp_loss) begin
        n_err++;
        $display("FAIL saturation loss %0d: got rst=%b loss=%0d expected 0 %0d", i, rst_o, loss_cnt_o, exp_loss);
      end
    end
    rst_i = 1'b1;
    tick();
    n_vec++;
    if ({loss_cnt_o, timeout_cnt_o} !== 4'b0000 || {pll_rst_o, rst_o, ready_o} !== 3'b110) begin
      n_err++;
      $display("FAIL sat_reset: got cnts=%b pll_rst/rst/ready=%b expected 0000 110",
               {loss_cnt_o, timeout_cnt_o}, {pll_rst_o, rst_o, ready_o});
    end
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_timeout();
    test_loss();
    test_stable_abort();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Consumer and controller for the board PLL's lock handshake. It synchronizes the PLL's asynchronous `locked` output into the system clock domain and requires lock to hold continuously for a qualification window before releasing the downstream system reset. It also drives the PLL `RST` input: the PLL is pulsed into reset at power-up and again whenever lock is not achieved within a timeout. It sits between the PLL wrapper and all logic clocked by the PLL outputs, and optionally counts lock-loss and timeout events.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `locked_i` synchronizer (≥2).
- `PLL_RST_CYCLES`, 16: width of each `pll_rst_o` pulse, in cycles (≥1).
- `STABLE_CYCLES`, 1024: continuous synchronized-lock cycles required before release (≥1).
- `TIMEOUT_CYCLES`, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again (≥1).
- `CNT_W`, 8: width of the event counters.

Ports:
- `clk_i`, in, 1: system clock, free-running and independent of the PLL.
- `rst_i`, in, 1: synchronous, active-high reset.
- `locked_i`, in, 1: PLL `LOCKED`, asynchronous to `clk_i`.
- `pll_rst_o`, out, 1: drives PLL `RST`; high = PLL held in reset.
- `rst_o`, out, 1: active-high reset for downstream logic.
- `ready_o`, out, 1: clocks qualified; always equal to `~rst_o`.
- `loss_cnt_o`, out, `CNT_W`: saturating count of lock losses seen in RUN.
- `timeout_cnt_o`, out, `CNT_W`: saturating count of WAIT_LOCK timeouts.

## Operation
- `lock_s` is the output of the last synchronizer flop. All decisions use `lock_s` only.
- Four states, one shared cycle counter `cnt`. `cnt` is wide enough for the largest of the three cycle parameters and clears on every state change.
- **PLL_RESET**
  - `pll_rst_o` = 1.
  - When `cnt` = `PLL_RST_CYCLES-1`: go to WAIT_LOCK.
  - `lock_s` is ignored in this state.
- **WAIT_LOCK**
  - If `lock_s` = 1: go to STABLE.
  - Else, when `cnt` = `TIMEOUT_CYCLES-1`: go to PLL_RESET and increment `timeout_cnt`.
- **STABLE**
  - If `lock_s` = 0: go to WAIT_LOCK. The timeout window restarts.
  - Else, when `cnt` = `STABLE_CYCLES-1`: go to RUN.
- **RUN**
  - `rst_o` = 0 and `ready_o` = 1.
  - If `lock_s` = 0: go to WAIT_LOCK and increment `loss_cnt`.
  - The PLL is not reset on a loss; it is given `TIMEOUT_CYCLES` to relock on its own.
- Output encoding: `pll_rst_o`, `rst_o` and `ready_o` are flops loaded from the next-state decode. They change on the same edge as the state register and are glitch-free.
- Counters saturate at 2^`CNT_W`−1 and clear only on `rst_i`.
- Reset values with `rst_i` = 1:
  - state = PLL_RESET, `cnt` = 0;
  - synchronizer flops = 0;
  - `pll_rst_o` = 1, `rst_o` = 1, `ready_o` = 0;
  - both counters = 0.
- Precedence: `rst_i` overrides every transition. `rst_i` asserted during RUN re-asserts `rst_o` and `pll_rst_o` on the next edge.

## Timing
- Synchronizer latency: `locked_i` reaches `lock_s` after `SYNC_STAGES` edges.
- Power-up release: with `lock_s` already 1, `rst_o` falls on edge `PLL_RST_CYCLES` + 1 + `STABLE_CYCLES`. Edge 1 is the first edge with `rst_i` = 0.
- Loss response: `rst_o` rises no more than `SYNC_STAGES` + 1 edges after `locked_i` falls.
- Glitches:
  - A `locked_i` drop shorter than one cycle may be missed.
  - Any drop captured in `lock_s` is acted on.
- Timeout period: each PLL_RESET + WAIT_LOCK retry cycle is exactly `PLL_RST_CYCLES` + `TIMEOUT_CYCLES` cycles.

## Configuration
- `LOCK_SEQ_STATUS_EN`:
  - Defined: `loss_cnt` and `timeout_cnt` registers are built as described.
  - Undefined: no counter flops are built, and `loss_cnt_o` and `timeout_cnt_o` are tied to 0.
  - Sequencing and all other outputs are identical in both cases.

## Test plan
Test parameters: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `STABLE_CYCLES`=8, `TIMEOUT_CYCLES`=32, `CNT_W`=2. Edge 1 = first edge after `rst_i` falls.
- **Power-up:** `locked_i` held 1 → `pll_rst_o` = 1 through edge 3 and 0 from edge 4; `rst_o` falls and `ready_o` rises on edge 13.
- **Timeout:** `locked_i` held 0 → `pll_rst_o` re-asserts on edge 36 for 4 cycles; `timeout_cnt_o` = 1; a second retry gives 2 at edge 72.
- **Loss in RUN:** drop `locked_i` for 3 cycles, then restore → `rst_o` = 1 within 3 edges; `loss_cnt_o` = 1; `rst_o` falls again 9 edges after `lock_s` returns high; `pll_rst_o` stays 0 throughout.
- **STABLE abort:** drop `locked_i` at STABLE `cnt`=5 → returns to WAIT_LOCK; `rst_o` is never released; after relock, the full 8-cycle window is required.
- **Saturation:** force 5 lock losses → `loss_cnt_o` = 3; assert `rst_i` → both counters = 0, `rst_o` = 1, `pll_rst_o` = 1.
- **Macro off:** repeat the loss scenario without `LOCK_SEQ_STATUS_EN` → identical `rst_o`/`pll_rst_o` waveform; counter outputs stay 0.
